// File: rtl/uart_rx_cfg.sv
`timescale 1ns/1ps
// Oversampling UART receiver: 2-flop line synchroniser, 3-sample majority vote
// around mid-bit, false-start rejection, optional parity, one or two stop bits.
module uart_rx_cfg #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] o_dout,
    output logic                 o_rx_done,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int DW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_LAST   = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_MID_M1 = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_MID    = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] T_MID_P1 = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [DW-1:0] D_LAST   = DW'(DATA_BITS - 1);
    localparam logic          P_ODD    = (PARITY_ODD != 0);
    localparam logic          HAS_PAR  = (PARITY_EN != 0);
    localparam logic          TWO_STOP = (STOP_BITS == 2);

    // state    | meaning
    // S_IDLE   | line idle, waiting for a b_tick that sees rx_s low
    // S_START  | start bit; mid-bit vote of 1 rejects it as a false start
    // S_DATA   | data bits, LSB first, shifted in at the mid-bit vote
    // S_PARITY | parity bit checked against the running XOR
    // S_STOP   | stop bit(s); leaves half a bit early on the last one
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    logic                 r_rx_meta;
    logic                 r_rx_s;
    state_t               r_state,      w_state_nxt;
    logic [TW-1:0]        r_tick,       w_tick_nxt;
    logic [DW-1:0]        r_bit,        w_bit_nxt;
    logic [DATA_BITS-1:0] r_shift,      w_shift_nxt;
    logic                 r_par,        w_par_nxt;
    logic                 r_ferr,       w_ferr_nxt;
    logic                 r_perr,       w_perr_nxt;
    logic                 r_stop_idx,   w_stop_idx_nxt;
    logic                 r_samp_a,     w_samp_a_nxt;
    logic                 r_samp_b,     w_samp_b_nxt;
    logic [DATA_BITS-1:0] r_dout,       w_dout_nxt;
    logic                 r_done,       w_done_nxt;
    logic                 r_frame_err,  w_frame_err_nxt;
    logic                 r_parity_err, w_parity_err_nxt;

    logic w_vote;
    logic w_at_mid;
    logic w_at_last;
    logic w_stop_last;
    logic w_ferr_upd;

    // Third sample is the live synchronised line at t = M+1.
    assign w_vote      = (r_samp_a & r_samp_b) | (r_samp_a & r_rx_s) | (r_samp_b & r_rx_s);
    assign w_at_mid    = b_tick && (r_tick == T_MID_P1);
    assign w_at_last   = b_tick && (r_tick == T_LAST);
    assign w_stop_last = TWO_STOP ? r_stop_idx : 1'b1;
    assign w_ferr_upd  = r_ferr | ~w_vote;

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_bit_nxt        = r_bit;
        w_shift_nxt      = r_shift;
        w_par_nxt        = r_par;
        w_ferr_nxt       = r_ferr;
        w_perr_nxt       = r_perr;
        w_stop_idx_nxt   = r_stop_idx;
        w_samp_a_nxt     = r_samp_a;
        w_samp_b_nxt     = r_samp_b;
        w_dout_nxt       = r_dout;
        w_done_nxt       = 1'b0;
        w_frame_err_nxt  = r_frame_err;
        w_parity_err_nxt = r_parity_err;

        if (b_tick && (r_state != S_IDLE)) begin
            if (r_tick == T_MID_M1) w_samp_a_nxt = r_rx_s;
            if (r_tick == T_MID)    w_samp_b_nxt = r_rx_s;
            w_tick_nxt = (r_tick == T_LAST) ? '0 : r_tick + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (b_tick && !r_rx_s) begin
                    w_state_nxt    = S_START;
                    w_tick_nxt     = '0;
                    w_bit_nxt      = '0;
                    w_shift_nxt    = '0;
                    w_par_nxt      = 1'b0;
                    w_ferr_nxt     = 1'b0;
                    w_perr_nxt     = 1'b0;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            S_START: begin
                if (w_at_mid && w_vote) begin
                    w_state_nxt = S_IDLE;
                    w_tick_nxt  = '0;
                end else if (w_at_last) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_at_mid) begin
                    w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
                    w_par_nxt   = r_par ^ w_vote;
                end
                if (w_at_last) begin
                    if (r_bit == D_LAST) begin
                        w_state_nxt    = HAS_PAR ? S_PARITY : S_STOP;
                        w_stop_idx_nxt = 1'b0;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_at_mid) w_perr_nxt = r_par ^ w_vote ^ P_ODD;
                if (w_at_last) begin
                    w_state_nxt    = S_STOP;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            S_STOP: begin
                if (w_at_mid) begin
                    w_ferr_nxt = w_ferr_upd;
                    if (w_stop_last) begin
                        w_state_nxt      = S_IDLE;
                        w_tick_nxt       = '0;
                        w_dout_nxt       = r_shift;
                        w_frame_err_nxt  = w_ferr_upd;
                        w_parity_err_nxt = HAS_PAR ? r_perr : 1'b0;
                        w_done_nxt       = 1'b1;
                    end
                end else if (w_at_last) begin
                    w_stop_idx_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_s       <= 1'b1;
            r_state      <= S_IDLE;
            r_tick       <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            r_par        <= 1'b0;
            r_ferr       <= 1'b0;
            r_perr       <= 1'b0;
            r_stop_idx   <= 1'b0;
            r_samp_a     <= 1'b1;
            r_samp_b     <= 1'b1;
            r_dout       <= '0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_rx_meta    <= rx;
            r_rx_s       <= r_rx_meta;
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_bit        <= w_bit_nxt;
            r_shift      <= w_shift_nxt;
            r_par        <= w_par_nxt;
            r_ferr       <= w_ferr_nxt;
            r_perr       <= w_perr_nxt;
            r_stop_idx   <= w_stop_idx_nxt;
            r_samp_a     <= w_samp_a_nxt;
            r_samp_b     <= w_samp_b_nxt;
            r_dout       <= w_dout_nxt;
            r_done       <= w_done_nxt;
            r_frame_err  <= w_frame_err_nxt;
            r_parity_err <= w_parity_err_nxt;
        end
    end

    assign o_dout       = r_dout;
    assign o_rx_done    = r_done;
    assign o_frame_err  = r_frame_err;
    assign o_parity_err = r_parity_err;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
`timescale 1ns/1ps
// Scoreboard bench for uart_rx_cfg: three configurations (8N1, 7E1, 8N2) share
// clk/rst/b_tick; a monitor pops the expected frame on every done pulse.
module tb_uart_rx_cfg;

    typedef struct {
        logic [8:0] dout;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic b_tick = 1'b0;
    int   tick_cnt = 0;
    logic rx_a, rx_b, rx_c;

    logic [7:0] dout_a, dout_c;
    logic [6:0] dout_b;
    logic       done_a, fe_a, pe_a, busy_a;
    logic       done_b, fe_b, pe_b, busy_b;
    logic       done_c, fe_c, pe_c, busy_c;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t q_c[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic stim_done = 1'b0;

    uart_rx_cfg u_a (
        .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx_a),
        .o_dout(dout_a), .o_rx_done(done_a), .o_frame_err(fe_a),
        .o_parity_err(pe_a), .o_busy(busy_a)
    );

    uart_rx_cfg #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx_b),
        .o_dout(dout_b), .o_rx_done(done_b), .o_frame_err(fe_b),
        .o_parity_err(pe_b), .o_busy(busy_b)
    );

    uart_rx_cfg #(.STOP_BITS(2)) u_c (
        .clk(clk), .rst(rst), .b_tick(b_tick), .rx(rx_c),
        .o_dout(dout_c), .o_rx_done(done_c), .o_frame_err(fe_c),
        .o_parity_err(pe_c), .o_busy(busy_c)
    );

    always #5 clk = ~clk;

    // One b_tick every 4 clk, changed on the falling edge.
    always @(negedge clk) begin
        tick_cnt = (tick_cnt == 3) ? 0 : tick_cnt + 1;
        b_tick   = (tick_cnt == 0);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: run exceeded 5 ms, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int inst, input logic [8:0] d, input logic fe, input logic pe);
        exp_t e;
        e.dout = d;
        e.ferr = fe;
        e.perr = pe;
        case (inst)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic mon_one(input int inst, input logic done, input logic [8:0] d,
                           input logic fe, input logic pe);
        exp_t e;
        logic have;
        if (!done) return;
        have = 1'b0;
        case (inst)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1'b1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1'b1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1'b1; end
        endcase
        n_vec++;
        if (!have) begin
            n_err++;
            $display("FAIL unexpected_done inst%0d: got dout=%h fe=%b pe=%b, required no pulse",
                     inst, d, fe, pe);
        end else if (d !== e.dout || fe !== e.ferr || pe !== e.perr) begin
            n_err++;
            $display("FAIL frame inst%0d: got dout=%h fe=%b pe=%b, required dout=%h fe=%b pe=%b",
                     inst, d, fe, pe, e.dout, e.ferr, e.perr);
        end
    endtask

    task automatic set_rx(input int inst, input logic v);
        case (inst)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    // Returns just after the clock edge that consumed the n-th b_tick.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (b_tick !== 1'b1) @(posedge clk);
        end
        #1;
    endtask

    task automatic hold(input int inst, input logic v, input int n);
        set_rx(inst, v);
        wait_ticks(n);
    endtask

    // par < 0 means no parity bit; glitch_bit >= 0 flips that data bit for
    // the single tick at the middle of the three vote samples.
    task automatic send_frame(input int inst, input int nbits, input logic [8:0] data,
                              input int par, input logic stop1, input logic stop2,
                              input int nstop, input int glitch_bit);
        hold(inst, 1'b0, 16);
        for (int i = 0; i < nbits; i++) begin
            if (i == glitch_bit) begin
                hold(inst, data[i], 9);
                hold(inst, ~data[i], 1);
                hold(inst, data[i], 6);
            end else begin
                hold(inst, data[i], 16);
            end
        end
        if (par >= 0) hold(inst, par[0], 16);
        hold(inst, stop1, 16);
        if (nstop == 2) hold(inst, stop2, 16);
    endtask

    initial begin
        rx_a = 1'b1;
        rx_b = 1'b1;
        rx_c = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_a_dout", {1'b0, dout_a}, 9'h000);
        chk("rst_a_flags", {5'b0, done_a, fe_a, pe_a, busy_a}, 9'h000);
        chk("rst_b_dout", {2'b0, dout_b}, 9'h000);
        chk("rst_b_flags", {5'b0, done_b, fe_b, pe_b, busy_b}, 9'h000);
        chk("rst_c_dout", {1'b0, dout_c}, 9'h000);
        chk("rst_c_flags", {5'b0, done_c, fe_c, pe_c, busy_c}, 9'h000);
        rst = 1'b0;

        fork
            begin
                while (!stim_done) begin
                    @(negedge clk);
                    mon_one(0, done_a, {1'b0, dout_a}, fe_a, pe_a);
                    mon_one(1, done_b, {2'b0, dout_b}, fe_b, pe_b);
                    mon_one(2, done_c, {1'b0, dout_c}, fe_c, pe_c);
                end
            end
            begin
                wait_ticks(4);

                // 8N1 back-to-back frames
                push_exp(0, 9'h0A5, 1'b0, 1'b0);
                push_exp(0, 9'h03C, 1'b0, 1'b0);
                send_frame(0, 8, 9'h0A5, -1, 1'b1, 1'b1, 1, -1);
                send_frame(0, 8, 9'h03C, -1, 1'b1, 1'b1, 1, -1);
                hold(0, 1'b1, 16);

                // one-tick low glitch on idle line: detected, then rejected
                hold(0, 1'b0, 1);
                chk("glitch_busy_after_detect", {8'b0, busy_a}, 9'h001);
                hold(0, 1'b1, 10);
                chk("glitch_idle_after_reject", {8'b0, busy_a}, 9'h000);
                hold(0, 1'b1, 16);

                // glitch in the middle of data bit 3 is outvoted
                push_exp(0, 9'h00F, 1'b0, 1'b0);
                send_frame(0, 8, 9'h00F, -1, 1'b1, 1'b1, 1, 3);
                hold(0, 1'b1, 16);

                // reset asserted half way through data bit 4 of 0x81
                hold(0, 1'b0, 16);
                hold(0, 1'b1, 16);
                hold(0, 1'b0, 48);
                hold(0, 1'b0, 8);
                chk("busy_mid_frame", {8'b0, busy_a}, 9'h001);
                rst  = 1'b1;
                rx_a = 1'b1;
                @(negedge clk);
                chk("midrst_dout", {1'b0, dout_a}, 9'h000);
                chk("midrst_flags", {5'b0, done_a, fe_a, pe_a, busy_a}, 9'h000);
                @(posedge clk);
                #1 rst = 1'b0;
                hold(0, 1'b1, 20);
                push_exp(0, 9'h081, 1'b0, 1'b0);
                send_frame(0, 8, 9'h081, -1, 1'b1, 1'b1, 1, -1);
                hold(0, 1'b1, 16);

                // break longer than a frame; line returns high before the
                // re-entered start bit reaches its mid-bit vote
                push_exp(0, 9'h000, 1'b1, 1'b0);
                hold(0, 1'b0, 160);
                hold(0, 1'b1, 40);
                chk("break_back_to_idle", {8'b0, busy_a}, 9'h000);

                // 7E1: correct parity, then wrong parity
                push_exp(1, 9'h041, 1'b0, 1'b0);
                send_frame(1, 7, 9'h041, 0, 1'b1, 1'b1, 1, -1);
                hold(1, 1'b1, 16);
                push_exp(1, 9'h041, 1'b0, 1'b1);
                send_frame(1, 7, 9'h041, 1, 1'b1, 1'b1, 1, -1);
                hold(1, 1'b1, 16);

                // 8N2: bad second stop bit, then a clean frame
                push_exp(2, 9'h055, 1'b1, 1'b0);
                send_frame(2, 8, 9'h055, -1, 1'b1, 1'b0, 2, -1);
                hold(2, 1'b1, 32);
                push_exp(2, 9'h0AA, 1'b0, 1'b0);
                send_frame(2, 8, 9'h0AA, -1, 1'b1, 1'b1, 2, -1);
                hold(2, 1'b1, 32);

                stim_done = 1'b1;
            end
        join

        chk("q_a_drained", 9'(q_a.size()), 9'd0);
        chk("q_b_drained", 9'(q_b.size()), 9'd0);
        chk("q_c_drained", 9'(q_c.size()), 9'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
